// File: rtl/sram_like_responder.sv
// SRAM-like slave: word memory behind an addr_ok/data_ok handshake with an
// in-order response queue and a fixed per-response latency.
module sram_like_responder #(
  parameter int unsigned MEM_AW  = 10,
  parameter int unsigned DEPTH   = 2,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [3:0]  wstrb,
  input  logic [31:0] wdata,
  input  logic        stall,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata
);

  localparam int unsigned WORDS = 1 << MEM_AW;
  localparam int unsigned PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW    = $clog2(DEPTH + 1);
  localparam int unsigned LW    = 4;
  localparam logic [LW-1:0] LAT_LOAD = LW'(LATENCY - 1);
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

  typedef struct packed {
    logic        is_read;
    logic [31:0] data;
  } entry_t;

  logic [31:0]   mem [WORDS];
  entry_t        queue [DEPTH];

  logic [PW-1:0] wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
  logic [CW-1:0] count, count_n;
  logic [LW-1:0] countdown, countdown_n;
  logic          data_ok_n;
  logic [31:0]   rdata_n;
  logic          accept, pop;
  logic [MEM_AW-1:0] idx;
  entry_t        new_entry, head_n;

  // Address bits outside the word index and the size field carry no meaning here
  logic unused_bits;
  assign unused_bits = ^{size, addr[1:0], addr[31:MEM_AW+2]};

  assign idx     = addr[MEM_AW+1:2];
  assign addr_ok = resetn & req & ~stall & (count < CW'(DEPTH));
  assign accept  = addr_ok;
  assign pop     = data_ok;

  // Entry captured on acceptance: reads snapshot the word before this edge's update
  always_comb begin
    new_entry         = '0;
    new_entry.is_read = ~wr;
    if (!wr) new_entry.data = mem[idx];
  end

  // Next-state for pointers, occupancy, head countdown and registered outputs
  always_comb begin
    wr_ptr_n    = wr_ptr;
    rd_ptr_n    = rd_ptr;
    count_n     = count;
    countdown_n = countdown;
    head_n      = queue[rd_ptr];
    data_ok_n   = 1'b0;
    rdata_n     = '0;

    if (accept) wr_ptr_n = (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PW'(1);
    if (pop)    rd_ptr_n = (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PW'(1);
    count_n = count + CW'(accept) - CW'(pop);

    // When the queue drains to empty in the same cycle, the new entry is the head
    if (accept && ((count - CW'(pop)) == '0)) head_n = new_entry;
    else                                      head_n = queue[rd_ptr_n];

    if (count_n == '0)                 countdown_n = '0;
    else if (pop || (count == '0))     countdown_n = LAT_LOAD;
    else if (countdown != '0)          countdown_n = countdown - LW'(1);

    data_ok_n = (count_n != '0) && (countdown_n == '0);
    if (data_ok_n && head_n.is_read) rdata_n = head_n.data;
  end

  // Control state and response outputs
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      countdown <= '0;
      data_ok   <= 1'b0;
      rdata     <= '0;
    end else begin
      wr_ptr    <= wr_ptr_n;
      rd_ptr    <= rd_ptr_n;
      count     <= count_n;
      countdown <= countdown_n;
      data_ok   <= data_ok_n;
      rdata     <= rdata_n;
    end
  end

  // Queue payload storage; validity is tracked by count and pointers
  always_ff @(posedge clk) begin
    if (accept) queue[wr_ptr] <= new_entry;
  end

  // Byte-lane memory update on accepted writes; contents survive reset
  always_ff @(posedge clk) begin
    if (accept && wr) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

endmodule
